intra_plane_pe: RTL

Plane-mode (Intra_16x16 / chroma) intra prediction sample generator. It consumes the per-4x4-block `seed`, `b` and `c` produced by the plane precalculation stage and emits one predicted 4-pixel row per cycle. It also returns the two boundary raw sums `PE0_sum_reg` and `PE3_sum_reg`, from which the precalculation stage derives the seed of the next block. It sits between the plane precalc block and the intra prediction output mux / reconstruction adder.

---
 rtl/intra_plane_pe.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/intra_plane_pe.sv
// intra_plane_pe
// Plane-mode intra prediction sample generator. For each 4x4 block it walks
// four rows, producing one clipped 4-pixel row per enabled cycle from the
// block seed and the horizontal/vertical gradients. It also returns the raw
// sums at (row 0, col 3) and (row 3, col 0) for the next block's seed.

module intra_plane_pe (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic               start,
   input  logic [4:0]         blk_idx,
   input  logic signed [14:0] seed,
   input  logic signed [11:0] b,
   input  logic signed [11:0] c,
   output logic               ready,
   output logic               pred_valid,
   output logic [1:0]         pred_row,
   output logic [4:0]         pred_blk,
   output logic [7:0]         pred_0,
   output logic [7:0]         pred_1,
   output logic [7:0]         pred_2,
   output logic [7:0]         pred_3,
   output logic               done,
   output logic [14:0]        PE0_sum_reg,
   output logic [14:0]        PE3_sum_reg
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_ROW  = 1'b1
   } state_t;

   state_t             state_r;
   state_t             state_nxt_s;
   logic [1:0]         r_r;
   logic [1:0]         r_nxt_s;
   logic signed [16:0] row_base_r;
   logic signed [11:0] b_r;
   logic signed [11:0] c_r;
   logic [4:0]         blk_r;
   logic               accept_s;

   logic signed [16:0] b_x_s;
   logic signed [16:0] b2_s;
   logic signed [16:0] b3_s;
   logic signed [16:0] c_x_s;
   logic signed [16:0] s0_s;
   logic signed [16:0] s1_s;
   logic signed [16:0] s2_s;
   logic signed [16:0] s3_s;

   // Round a raw sum to a pixel: (s + 16) >>> 5, then clamp to 0..255.
   function automatic logic [7:0] clip_pix(input logic signed [16:0] s);
      logic signed [16:0] t;
      t = (s + 17'sd16) >>> 5;
      if (t < 17'sd0) begin
         clip_pix = 8'd0;
      end else if (t > 17'sd255) begin
         clip_pix = 8'd255;
      end else begin
         clip_pix = t[7:0];
      end
   endfunction

   assign ready    = (state_r == ST_IDLE) || ((state_r == ST_ROW) && (r_r == 2'd3));
   assign accept_s = ena && start && ready;

   // Gradient multiples by shift-add only: b, 2b, 3b.
   assign b_x_s = {{5{b_r[11]}}, b_r};
   assign b2_s  = b_x_s <<< 1;
   assign b3_s  = b_x_s + b2_s;
   assign c_x_s = {{5{c_r[11]}}, c_r};

   // Raw sums of the four columns of the row currently being computed.
   assign s0_s = row_base_r;
   assign s1_s = row_base_r + b_x_s;
   assign s2_s = row_base_r + b2_s;
   assign s3_s = row_base_r + b3_s;

   // Next state and row counter: start wins, otherwise step rows while enabled.
   always_comb begin
      state_nxt_s = state_r;
      r_nxt_s     = r_r;
      if (accept_s) begin
         state_nxt_s = ST_ROW;
         r_nxt_s     = 2'd0;
      end else if (ena && (state_r == ST_ROW)) begin
         r_nxt_s = r_r + 2'd1;
         if (r_r == 2'd3) begin
            state_nxt_s = ST_IDLE;
         end else begin
            state_nxt_s = ST_ROW;
         end
      end else begin
         state_nxt_s = state_r;
         r_nxt_s     = r_r;
      end
   end

   // FSM state and row counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         r_r     <= 2'd0;
      end else begin
         state_r <= state_nxt_s;
         r_r     <= r_nxt_s;
      end
   end

   // Block parameter latch, row accumulator and registered prediction outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_base_r  <= 17'sd0;
         b_r         <= 12'sd0;
         c_r         <= 12'sd0;
         blk_r       <= 5'd0;
         pred_valid  <= 1'b0;
         pred_row    <= 2'd0;
         pred_blk    <= 5'd0;
         pred_0      <= 8'd0;
         pred_1      <= 8'd0;
         pred_2      <= 8'd0;
         pred_3      <= 8'd0;
         done        <= 1'b0;
         PE0_sum_reg <= 15'd0;
         PE3_sum_reg <= 15'd0;
      end else if (ena) begin
         if (state_r == ST_ROW) begin
            pred_0     <= clip_pix(s0_s);
            pred_1     <= clip_pix(s1_s);
            pred_2     <= clip_pix(s2_s);
            pred_3     <= clip_pix(s3_s);
            pred_row   <= r_r;
            pred_valid <= 1'b1;
            pred_blk   <= blk_r;
            done       <= (r_r == 2'd3);
            row_base_r <= row_base_r + c_x_s;
            if (r_r == 2'd0) begin
               PE0_sum_reg <= s3_s[14:0];
            end
            if (r_r == 2'd3) begin
               PE3_sum_reg <= s0_s[14:0];
            end
         end else if (!accept_s) begin
            pred_valid <= 1'b0;
            done       <= 1'b0;
         end
         // A start overrides the accumulator update on the row-3 edge.
         if (accept_s) begin
            row_base_r <= {{2{seed[14]}}, seed};
            b_r        <= b;
            c_r        <= c;
            blk_r      <= blk_idx;
         end
      end
   end

endmodule
